// File: rtl/stream_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pack_pkg
// Desc     : Shared widths and packed FIFO entry layout for stream_pack.
// Revision : 1.0 - initial release
// ============================================================================
package stream_pack_pkg;

    localparam int unsigned c_ratio_max = 16;

    // Pointer operation for one FIFO cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Lane count must hold the value ratio itself, hence the extra bit.
    function automatic int unsigned lanes_width(input int unsigned ratio);
        return $clog2(ratio) + 1;
    endfunction

    function automatic int unsigned lc_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int unsigned data_width(input int unsigned dw, input int unsigned ratio);
        return dw * ratio;
    endfunction

    function automatic int unsigned lanes_lsb(input int unsigned dw, input int unsigned ratio);
        return data_width(dw, ratio);
    endfunction

    function automatic int unsigned eos_pos(input int unsigned dw, input int unsigned ratio);
        return lanes_lsb(dw, ratio) + lanes_width(ratio);
    endfunction

    function automatic int unsigned entry_width(input int unsigned dw, input int unsigned ratio);
        return eos_pos(dw, ratio) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_pack_fifo
// Desc     : Dual-pointer register FIFO with first-word-fall-through head.
// Revision : 1.0 - initial release
// ============================================================================
module stream_pack_fifo
    import stream_pack_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDRWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic                 empty,
    output logic                 full,
    output logic [ADDRWIDTH:0]   level
);

    localparam int unsigned c_depth = 1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] c_ptr_one = (ADDRWIDTH + 1)'(1);

    logic [WIDTH-1:0]   r_mem [c_depth];
    logic [ADDRWIDTH:0] r_wr_ptr;
    logic [ADDRWIDTH:0] r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;
    fifo_op_e           w_op;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[ADDRWIDTH-1:0] == r_rd_ptr[ADDRWIDTH-1:0]) &&
                   (r_wr_ptr[ADDRWIDTH] != r_rd_ptr[ADDRWIDTH]);
    assign level = r_wr_ptr - r_rd_ptr;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign w_op      = fifo_op_e'({w_do_push, w_do_pop});

    assign head_data = r_mem[r_rd_ptr[ADDRWIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[ADDRWIDTH-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            case (w_op)
                OP_PUSH: r_wr_ptr <= r_wr_ptr + c_ptr_one;
                OP_POP:  r_rd_ptr <= r_rd_ptr + c_ptr_one;
                OP_BOTH: begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                default: begin
                    r_wr_ptr <= r_wr_ptr;
                    r_rd_ptr <= r_rd_ptr;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_pack.sv
`default_nettype none
// ============================================================================
// Module   : stream_pack
// Desc     : Packs RATIO narrow words into one wide word, buffered in an FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module stream_pack
    import stream_pack_pkg::*;
#(
    parameter int unsigned DATAWIDTH    = 8,
    parameter int unsigned RATIO        = 4,
    parameter int unsigned ADDRWIDTH    = 4,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            input_en,
    input  logic                            input_eos,
    input  logic [DATAWIDTH-1:0]            input_data,
    output logic                            input_rdy,
    input  logic                            output_en,
    output logic                            output_rdy,
    output logic                            output_eos,
    output logic [lanes_width(RATIO)-1:0]   output_lanes,
    output logic [DATAWIDTH*RATIO-1:0]      output_data,
    output logic [ADDRWIDTH:0]              level,
    output logic                            almost_full
);

    localparam int unsigned c_lw        = lanes_width(RATIO);
    localparam int unsigned c_lcw       = lc_width(RATIO);
    localparam int unsigned c_dw        = data_width(DATAWIDTH, RATIO);
    localparam int unsigned c_lanes_lsb = lanes_lsb(DATAWIDTH, RATIO);
    localparam int unsigned c_eos_pos   = eos_pos(DATAWIDTH, RATIO);
    localparam int unsigned c_ew        = entry_width(DATAWIDTH, RATIO);
    localparam int unsigned c_depth     = 1 << ADDRWIDTH;
    localparam logic [c_lcw-1:0] c_lc_last = c_lcw'(RATIO - 1);

    logic [c_lcw-1:0] r_lc;
    logic [c_dw-1:0]  r_pack;
    logic [c_dw-1:0]  w_merged;
    logic [c_lw-1:0]  w_lanes;
    logic [c_ew-1:0]  w_entry;
    logic [c_ew-1:0]  w_head;
    logic             w_accept;
    logic             w_last;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;

    assign input_rdy = !w_full;
    assign w_accept  = input_en && input_rdy;
    assign w_last    = (r_lc == c_lc_last) || input_eos;
    assign w_push    = w_accept && w_last;
    assign w_lanes   = c_lw'(r_lc) + c_lw'(1);

    always_comb begin
        w_merged = r_pack;
        w_merged[int'(r_lc)*DATAWIDTH +: DATAWIDTH] = input_data;
    end

    always_comb begin
        w_entry = '0;
        w_entry[c_dw-1:0]               = w_merged;
        w_entry[c_lanes_lsb +: c_lw]    = w_lanes;
        w_entry[c_eos_pos]              = input_eos;
    end

    // Pack register is cleared on push so lanes beyond an early eos read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lc   <= '0;
            r_pack <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_lc   <= '0;
                r_pack <= '0;
            end else begin
                r_lc   <= r_lc + c_lcw'(1);
                r_pack <= w_merged;
            end
        end
    end

    stream_pack_fifo #(
        .WIDTH     (c_ew),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_entry),
        .pop       (w_pop),
        .head_data (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .level     (level)
    );

    assign output_rdy = !w_empty;
    assign w_pop      = output_en && output_rdy;

    assign output_data  = output_rdy ? w_head[c_dw-1:0]            : '0;
    assign output_lanes = output_rdy ? w_head[c_lanes_lsb +: c_lw] : '0;
    assign output_eos   = output_rdy ? w_head[c_eos_pos]           : 1'b0;

    assign almost_full = ((c_depth - 32'(level)) <= AFULL_MARGIN);

endmodule

`default_nettype wire

// File: tb/tb_stream_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_pack
// Desc     : Scoreboard bench for stream_pack (ratio=4 and ratio=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stream_pack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ratio=4, datawidth=8, depth=16, margin=2
    logic        a_in_en, a_in_eos, a_in_rdy, a_out_en, a_out_rdy, a_out_eos, a_afull;
    logic [7:0]  a_in_data;
    logic [2:0]  a_out_lanes;
    logic [31:0] a_out_data;
    logic [4:0]  a_level;

    // ratio=1, datawidth=16, depth=4, margin=1
    logic        b_in_en, b_in_eos, b_in_rdy, b_out_en, b_out_rdy, b_out_eos, b_afull;
    logic [15:0] b_in_data;
    logic [0:0]  b_out_lanes;
    logic [15:0] b_out_data;
    logic [2:0]  b_level;

    stream_pack #(.DATAWIDTH(8), .RATIO(4), .ADDRWIDTH(4), .AFULL_MARGIN(2)) u_dut_a (
        .clk(clk), .reset(rst_n), .input_en(a_in_en), .input_eos(a_in_eos),
        .input_data(a_in_data), .input_rdy(a_in_rdy), .output_en(a_out_en),
        .output_rdy(a_out_rdy), .output_eos(a_out_eos), .output_lanes(a_out_lanes),
        .output_data(a_out_data), .level(a_level), .almost_full(a_afull)
    );

    stream_pack #(.DATAWIDTH(16), .RATIO(1), .ADDRWIDTH(2), .AFULL_MARGIN(1)) u_dut_b (
        .clk(clk), .reset(rst_n), .input_en(b_in_en), .input_eos(b_in_eos),
        .input_data(b_in_data), .input_rdy(b_in_rdy), .output_en(b_out_en),
        .output_rdy(b_out_rdy), .output_eos(b_out_eos), .output_lanes(b_out_lanes),
        .output_data(b_out_data), .level(b_level), .almost_full(b_afull)
    );

    typedef struct packed {
        logic        eos;
        logic [2:0]  lanes;
        logic [31:0] data;
    } a_ent_t;

    a_ent_t      a_sb[$];
    int          m_lc = 0;
    logic [31:0] m_pack = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Drive one word for one cycle; the model packs it only if the DUT can accept it.
    task automatic put_a(input logic [7:0] d, input logic e);
        bit     acc;
        a_ent_t ent;
        acc = a_in_rdy;
        a_in_en = 1'b1; a_in_data = d; a_in_eos = e;
        if (acc) begin
            m_pack[m_lc*8 +: 8] = d;
            if (m_lc == 3 || e) begin
                ent.eos = e; ent.lanes = 3'(m_lc + 1); ent.data = m_pack;
                a_sb.push_back(ent);
                m_lc = 0; m_pack = '0;
            end else begin
                m_lc++;
            end
        end
        @(negedge clk);
        a_in_en = 1'b0; a_in_eos = 1'b0;
    endtask

    task automatic pop_a(output a_ent_t got, output bit ok);
        int t;
        t = 0;
        while (!a_out_rdy && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = a_out_rdy;
        got.eos = a_out_eos; got.lanes = a_out_lanes; got.data = a_out_data;
        if (ok) begin
            a_out_en = 1'b1;
            @(negedge clk);
            a_out_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a_in_rdy, a_out_rdy, a_out_eos, a_out_lanes, a_out_data, a_level, a_afull} !==
            {1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 5'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_a: rdy=%b ordy=%b eos=%b lanes=%0d data=%h level=%0d afull=%b, required 1 0 0 0 0 0 0",
                     a_in_rdy, a_out_rdy, a_out_eos, a_out_lanes, a_out_data, a_level, a_afull);
        end
        n_cmp++;
        if ({b_in_rdy, b_out_rdy, b_out_data, b_level, b_afull} !== {1'b1, 1'b0, 16'd0, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_b: rdy=%b ordy=%b data=%h level=%0d afull=%b, required 1 0 0 0 0",
                     b_in_rdy, b_out_rdy, b_out_data, b_level, b_afull);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pack();
        a_ent_t got, exp;
        bit     ok;
        logic [31:0] lit [2];
        lit[0] = 32'h04030201; lit[1] = 32'h08070605;
        for (int i = 1; i <= 8; i++) begin
            put_a(8'(i), 1'b0);
            if (i == 3 || i == 4) begin
                n_cmp++;
                if (a_out_rdy !== (i >= 4)) begin
                    n_bad++;
                    $display("FAIL pack_latency_w%0d: output_rdy=%b, required %b", i, a_out_rdy, (i >= 4));
                end
            end
        end
        n_cmp++;
        if (a_level !== 5'd2) begin
            n_bad++;
            $display("FAIL pack_level: level=%0d, required 2", a_level);
        end
        for (int k = 0; k < 2; k++) begin
            pop_a(got, ok);
            exp = (a_sb.size() != 0) ? a_sb.pop_front() : '0;
            n_cmp++;
            if (!ok || got !== exp || got.data !== lit[k]) begin
                n_bad++;
                $display("FAIL pack_pop%0d: rdy=%b eos=%b lanes=%0d data=%h, required rdy=1 eos=%b lanes=%0d data=%h",
                         k, ok, got.eos, got.lanes, got.data, exp.eos, exp.lanes, lit[k]);
            end
        end
        n_cmp++;
        if ({a_out_rdy, a_out_data, a_out_lanes, a_level} !== {1'b0, 32'd0, 3'd0, 5'd0}) begin
            n_bad++;
            $display("FAIL pack_drained: rdy=%b data=%h lanes=%0d level=%0d, required 0 0 0 0",
                     a_out_rdy, a_out_data, a_out_lanes, a_level);
        end
    endtask

    task automatic test_eos();
        a_ent_t got, exp;
        bit     ok;
        put_a(8'hA1, 1'b0); put_a(8'hA2, 1'b0); put_a(8'hA3, 1'b1);
        for (int i = 0; i < 4; i++) put_a(8'hB1 + 8'(i), 1'b0);
        for (int k = 0; k < 2; k++) begin
            pop_a(got, ok);
            exp = (a_sb.size() != 0) ? a_sb.pop_front() : '0;
            n_cmp++;
            if (!ok || got !== exp ||
                got.data !== ((k == 0) ? 32'h00A3A2A1 : 32'hB4B3B2B1)) begin
                n_bad++;
                $display("FAIL eos_pop%0d: rdy=%b eos=%b lanes=%0d data=%h, required eos=%b lanes=%0d data=%h",
                         k, ok, got.eos, got.lanes, got.data, exp.eos, exp.lanes, exp.data);
            end
        end
    endtask

    task automatic test_fill_and_overflow();
        a_ent_t got, exp;
        bit     ok;
        int     npop;
        for (int p = 0; p < 16; p++) begin
            for (int l = 0; l < 4; l++) put_a(8'(p*4 + l), 1'b0);
            n_cmp++;
            if (a_level !== 5'(p + 1) || a_afull !== ((p + 1) >= 14)) begin
                n_bad++;
                $display("FAIL fill_p%0d: level=%0d afull=%b, required level=%0d afull=%b",
                         p, a_level, a_afull, p + 1, ((p + 1) >= 14));
            end
        end
        n_cmp++;
        if (a_in_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL full_rdy: input_rdy=%b, required 0", a_in_rdy);
        end
        put_a(8'hEE, 1'b1);
        n_cmp++;
        if (a_level !== 5'd16) begin
            n_bad++;
            $display("FAIL full_ignore: level=%0d, required 16", a_level);
        end
        // Write and read together while full: only the read happens.
        got.eos = a_out_eos; got.lanes = a_out_lanes; got.data = a_out_data;
        if (a_in_rdy) $display("note: input_rdy high while full");
        a_in_en = 1'b1; a_in_data = 8'h5A; a_in_eos = 1'b1; a_out_en = 1'b1;
        @(negedge clk);
        a_in_en = 1'b0; a_in_eos = 1'b0; a_out_en = 1'b0;
        exp = (a_sb.size() != 0) ? a_sb.pop_front() : '0;
        n_cmp++;
        if (got !== exp || a_level !== 5'd15 || a_in_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL full_simul: data=%h level=%0d rdy=%b, required data=%h level=15 rdy=1",
                     got.data, a_level, a_in_rdy, exp.data);
        end
        put_a(8'h5B, 1'b1);
        n_cmp++;
        if (a_level !== 5'd16) begin
            n_bad++;
            $display("FAIL full_refill: level=%0d, required 16", a_level);
        end
        npop = 0;
        while (a_sb.size() != 0 && npop < 20) begin
            pop_a(got, ok);
            exp = a_sb.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_bad++;
                $display("FAIL drain_pop%0d: rdy=%b eos=%b lanes=%0d data=%h, required eos=%b lanes=%0d data=%h",
                         npop, ok, got.eos, got.lanes, got.data, exp.eos, exp.lanes, exp.data);
            end
            npop++;
        end
        n_cmp++;
        if (npop !== 16 || a_level !== 5'd0 || a_out_data !== 32'd0 || a_afull !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_end: pops=%0d level=%0d data=%h afull=%b, required 16 0 0 0",
                     npop, a_level, a_out_data, a_afull);
        end
    endtask

    task automatic test_reset_mid();
        a_ent_t got, exp;
        bit     ok;
        for (int i = 0; i < 22; i++) put_a(8'h40 + 8'(i), 1'b0);
        n_cmp++;
        if (a_level !== 5'd5) begin
            n_bad++;
            $display("FAIL rstmid_pre: level=%0d, required 5", a_level);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_out_rdy, a_level, a_in_rdy, a_out_data} !== {1'b0, 5'd0, 1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL rstmid_async: ordy=%b level=%0d rdy=%b data=%h, required 0 0 1 0",
                     a_out_rdy, a_level, a_in_rdy, a_out_data);
        end
        a_sb.delete(); m_lc = 0; m_pack = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) put_a(8'hC1 + 8'(i), 1'b0);
        pop_a(got, ok);
        exp = (a_sb.size() != 0) ? a_sb.pop_front() : '0;
        n_cmp++;
        if (!ok || got !== exp || got.data !== 32'hC4C3C2C1) begin
            n_bad++;
            $display("FAIL rstmid_post: rdy=%b lanes=%0d data=%h, required lanes=4 data=c4c3c2c1",
                     ok, got.lanes, got.data);
        end
    endtask

    task automatic test_ratio1();
        a_out_en = 1'b1;
        @(negedge clk);
        a_out_en = 1'b0;
        n_cmp++;
        if (a_level !== 5'd0 || a_out_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_pop: level=%0d ordy=%b, required 0 0", a_level, a_out_rdy);
        end
        b_in_en = 1'b1; b_in_data = 16'h1234; b_in_eos = 1'b1;
        @(negedge clk);
        b_in_en = 1'b0; b_in_eos = 1'b0;
        n_cmp++;
        if ({b_out_rdy, b_out_data, b_out_lanes, b_out_eos} !== {1'b1, 16'h1234, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL r1_eos: ordy=%b data=%h lanes=%0d eos=%b, required 1 1234 1 1",
                     b_out_rdy, b_out_data, b_out_lanes, b_out_eos);
        end
        b_in_en = 1'b1; b_in_data = 16'hBEEF; b_out_en = 1'b1;
        @(negedge clk);
        b_in_en = 1'b0; b_out_en = 1'b0;
        n_cmp++;
        if ({b_level, b_out_rdy, b_out_data, b_out_lanes, b_out_eos} !== {3'd1, 1'b1, 16'hBEEF, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL r1_plain: level=%0d ordy=%b data=%h lanes=%0d eos=%b, required 1 1 beef 1 0",
                     b_level, b_out_rdy, b_out_data, b_out_lanes, b_out_eos);
        end
        b_out_en = 1'b1;
        @(negedge clk);
        b_out_en = 1'b0;
        n_cmp++;
        if (b_level !== 3'd0 || b_out_data !== 16'd0) begin
            n_bad++;
            $display("FAIL r1_drain: level=%0d data=%h, required 0 0", b_level, b_out_data);
        end
    endtask

    initial begin
        a_in_en = 1'b0; a_in_eos = 1'b0; a_in_data = '0; a_out_en = 1'b0;
        b_in_en = 1'b0; b_in_eos = 1'b0; b_in_data = '0; b_out_en = 1'b0;
        test_reset();
        test_pack();
        test_eos();
        test_fill_and_overflow();
        test_reset_mid();
        test_ratio1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire

// File: doc/stream_pack.md
Name: stream_pack

Overview:
- Parametrised successor to the CoBuilder stream wrapper.
- Accepts a narrow stream of `datawidth`-bit words with an end-of-stream flag and packs `ratio` consecutive words into one wide word.
- Buffers packed words in an internal FIFO with first-word-fall-through output.
- Adds a fill level, an almost-full flag, and a valid-lane count for the partial word that closes a stream on eos.
- Sits between a narrow CoBuilder producer process and a wide consumer (memory or bus master).

Parameters:
- datawidth, 8: input lane width in bits.
- ratio, 4: lanes per packed output word; legal range 1..16; ratio=1 gives a plain buffered stream.
- addrwidth, 4: FIFO depth is 2^addrwidth packed words.
- afull_margin, 2: almost_full asserts when free slots <= afull_margin.

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- input_en, input, 1: write strobe from producer.
- input_eos, input, 1: marks the current input word as the last of the stream.
- input_data, input, datawidth: input lane data.
- input_rdy, output, 1: producer may write this cycle.
- output_en, input, 1: read strobe from consumer; pops the head word.
- output_rdy, output, 1: head word valid.
- output_eos, output, 1: head word closes a stream.
- output_lanes, output, clog2(ratio)+1: number of valid lanes in the head word (1..ratio).
- output_data, output, datawidth*ratio: packed head word.
- level, output, addrwidth+1: packed words currently held, 0..2^addrwidth.
- almost_full, output, 1: (2^addrwidth - level) <= afull_margin.

Behaviour:
- **Reset (async assert, sync release):**
  - read/write pointers, lane counter and pack register clear to 0.
  - input_rdy=1, output_rdy=0, output_eos=0, output_lanes=0, output_data=0, level=0, almost_full=0 (1 if afull_margin >= depth).
  - Assertion mid-stream discards any partial pack and all buffered words.
- **Accept rule:** accept = input_en && input_rdy; input_rdy = !full, combinational from registered pointers. input_en while !input_rdy is ignored: no state change, word dropped.
- **Packing:**
  - Lane counter lc runs 0..ratio-1.
  - An accepted word writes lane lc, bits [lc*datawidth +: datawidth]; lane 0 is the first word, little-endian.
- **Push to FIFO:** on accept with (lc==ratio-1 || input_eos), push {eos, lanes=lc+1, pack with the current word merged}.
  - Unused upper lanes are zero.
  - lc returns to 0 and the pack register clears.
  - Otherwise lc increments.
- **Latency:** push at edge N; output_rdy, output_data, output_eos and output_lanes are valid after edge N (FWFT). Fall-through into an empty FIFO therefore costs 1 cycle after the completing input word.
- **Pop:** output_en && output_rdy advances the read pointer. output_en while empty is ignored.
- **Gating:** output_data, output_eos and output_lanes are forced to 0 while output_rdy=0.
- **Simultaneous push and pop:** level unchanged; both pointers advance. When full, input_rdy=0 that cycle regardless of output_en (no same-cycle pass-through).
- **Pointers:** addrwidth+1 bits, wrap modulo 2^(addrwidth+1).
  - empty = pointers equal.
  - full = addresses equal with differing MSB.
  - level = wr - rd, modulo arithmetic.
- **Mid-pack stall:** words held in the pack register do not count in level. input_rdy reflects FIFO space only; a completing word that meets a full FIFO is held off by input_rdy=0.
- **eos on lane 0:** pushes a 1-lane word with output_eos=1.
- **ratio=1:** every accepted word pushes immediately with lanes=1.

Decomposition:
- Shared package: lane-count width function (clog2), and the packed-entry layout constants (eos bit position, lanes field offset/width, data field width).
- One natural sub-module: stream_pack_fifo.
  - Parametrised width/addrwidth.
  - Dual-pointer RAM FIFO with FWFT head register, full/empty/level.
- The packer and almost_full logic stay in stream_pack.

Test Plan:
- Reset, then 8 accepted words 0x01..0x08, no eos, ratio=4 -> two pops: output_data 0x04030201 then 0x08070605, lanes=4, output_eos=0; output_rdy rises 1 cycle after the 4th word.
- Words 0xA1,0xA2,0xA3 with eos on 0xA3 -> one word 0x00A3A2A1, lanes=3, output_eos=1; the next stream starts at lane 0.
- Fill 16 packed words (addrwidth=4), output_en=0 -> level=16, input_rdy=0, almost_full=1 from level 14; extra input_en ignored; pop all 16 in order, last pop gives level=0.
- At level=16 assert input_en and output_en together -> no write, one pop, level=15; next cycle the write is accepted.
- Assert reset low mid-pack (lc=2) with 5 words buffered -> asynchronous clear: output_rdy=0, level=0, input_rdy=1; the first word after release lands in lane 0.
- ratio=1, datawidth=16: 0x1234 with eos -> output_data=0x1234, lanes=1, output_eos=1, 1-cycle latency.
